// File: rtl/spi_rx_pkg.sv
// Shared types for the SPI byte receiver: FSM states and the 9-bit FIFO entry.
package spi_rx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic              dc;
    logic [BYTE_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; accepts a write while full if a read frees a slot.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic             wr_ok_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_rd;

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en && !empty_c;
  assign wr_ok_c   = wr_en && (!full_c || do_rd);
  assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_ok_c);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (wr_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 receiver: bytes tagged with D/C are queued for a valid/ready consumer.
// Define SPI_RX_STATS_EN to add saturating byte_count / frame_count outputs.
module spi_byte_rx
  import spi_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_sk,
  input  logic              spi_do,
  input  logic              spi_cs_n,
  input  logic              spi_dc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_dc,
  output logic              frame_active,
  output logic              frame_start,
  output logic              frame_abort,
  output logic              overflow,
  input  logic              clr_overflow
`ifdef SPI_RX_STATS_EN
  ,
  output logic [15:0]       byte_count,
  output logic [15:0]       frame_count
`endif
);

  localparam int unsigned PIN_W   = 4;
  localparam int unsigned CNT_W   = 3;
  localparam logic [PIN_W-1:0] PIN_RST = 4'b0100;

  // Pin vector order: {dc, cs_n, do, sk}
  logic [PIN_W-1:0]   sync_q [SYNC_STAGES];
  logic [PIN_W-1:0]   pin_s;
  logic [1:0]         dly_q;
  logic [SYNC_STAGES:0] init_q;
  logic               init_done, sk_rise, cs_fall, cs_rise;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic               push_q, push_d;
  rx_entry_t          entry_q, entry_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_abort_q, frame_abort_d;
  logic               frame_active_q;
  logic               overflow_q, overflow_d;

  rx_entry_t          head;
  logic               full_c, empty_c, wr_ok_c;

  assign pin_s     = sync_q[SYNC_STAGES-1];
  assign sk_rise   = pin_s[0] && !dly_q[0];
  assign cs_fall   = !pin_s[2] && dly_q[1];
  assign cs_rise   = pin_s[2] && !dly_q[1];
  // Edges only count once the delay flop holds a real sample, so a CS held low through reset is ignored.
  assign init_done = init_q[SYNC_STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= PIN_RST;
      dly_q  <= 2'b10;
      init_q <= '0;
    end else begin
      sync_q[0] <= {spi_dc, spi_cs_n, spi_do, spi_sk};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      dly_q  <= {pin_s[2], pin_s[0]};
      init_q <= {init_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame / bit FSM; CS rising takes priority over a coincident SK edge.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push_d        = 1'b0;
    entry_d       = entry_q;
    frame_start_d = 1'b0;
    frame_abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall && init_done) begin
          state_d       = SHIFT;
          bit_cnt_d     = '0;
          shift_d       = '0;
          frame_start_d = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d       = IDLE;
          frame_abort_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
        end else if (sk_rise) begin
          shift_d   = {shift_q[BYTE_W-2:0], pin_s[1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            push_d       = 1'b1;
            entry_d.dc   = pin_s[3];
            entry_d.data = shift_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (push_q && !wr_ok_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      push_q         <= 1'b0;
      entry_q        <= '0;
      frame_start_q  <= 1'b0;
      frame_abort_q  <= 1'b0;
      frame_active_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      push_q         <= push_d;
      entry_q        <= entry_d;
      frame_start_q  <= frame_start_d;
      frame_abort_q  <= frame_abort_d;
      frame_active_q <= !pin_s[2];
      overflow_q     <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .wr_en     (push_q),
    .wr_data   (entry_q),
    .rd_en     (out_ready),
    .rd_data_c (head),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .wr_ok_c   (wr_ok_c)
  );

  assign out_valid    = !empty_c;
  assign out_data     = head.data;
  assign out_dc       = head.dc;
  assign frame_active = frame_active_q;
  assign frame_start  = frame_start_q;
  assign frame_abort  = frame_abort_q;
  assign overflow     = overflow_q;

`ifdef SPI_RX_STATS_EN
  logic [15:0] byte_count_q, frame_count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_count_q  <= '0;
      frame_count_q <= '0;
    end else begin
      if (wr_ok_c && byte_count_q != 16'hFFFF) byte_count_q <= byte_count_q + 16'd1;
      if (frame_start_q && frame_count_q != 16'hFFFF) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign byte_count  = byte_count_q;
  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: framing, abort, overflow, full push+pop, reset mid-frame.
module tb_spi_byte_rx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned SYNC  = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       spi_sk = 1'b0, spi_do = 1'b0, spi_cs_n = 1'b1, spi_dc = 1'b0;
  logic       out_valid, out_ready = 1'b0, out_dc;
  logic [7:0] out_data;
  logic       frame_active, frame_start, frame_abort, overflow;
  logic       clr_overflow = 1'b0;
`ifdef SPI_RX_STATS_EN
  logic [15:0] byte_count, frame_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int fs_cnt = 0;
  int fa_cnt = 0;
  int lat = 0;
  logic [8:0] got_q [$];

  spi_byte_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .spi_sk       (spi_sk),
    .spi_do       (spi_do),
    .spi_cs_n     (spi_cs_n),
    .spi_dc       (spi_dc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dc       (out_dc),
    .frame_active (frame_active),
    .frame_start  (frame_start),
    .frame_abort  (frame_abort),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef SPI_RX_STATS_EN
    ,
    .byte_count   (byte_count),
    .frame_count  (frame_count)
`endif
  );

  always #5 clk = ~clk;

  // Outputs are observed on the falling edge; stimulus moves 1 ns after the rising edge.
  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (frame_abort) fa_cnt++;
    if (resetn && out_valid && out_ready) got_q.push_back({out_dc, out_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input string tag, input logic [8:0] exp);
    if (got_q.size() > 0) check(tag, 32'(got_q.pop_front()), 32'(exp));
    else                  check(tag, 32'hDEAD, 32'(exp));
  endtask

  // mode 0: plain; 1: pulse out_ready in the cycle the last bit is pushed; 2: measure latency
  task automatic send_byte(input logic dc, input logic [7:0] b, input int mode);
    spi_dc = dc;
    for (int i = 7; i >= 0; i--) begin
      spi_do = b[i];
      tick(6);
      spi_sk = 1'b1;
      if (i == 0 && mode == 1) begin
        tick(SYNC + 1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(6 - SYNC - 2);
      end else if (i == 0 && mode == 2) begin
        lat = 1;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          lat++;
          if (out_valid) break;
        end
        tick(2);
      end else begin
        tick(6);
      end
      spi_sk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(6);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  int fs0, fa0;

  initial begin
    tick(3);
    check("reset_outs", 32'({out_valid, out_data, out_dc, frame_active, frame_start,
                             frame_abort, overflow}), 32'h0);
    resetn = 1'b1;
    tick(5);

    // Single command byte, latency, framing pulses
    cs_low();
    check("frame_active", 32'(frame_active), 32'h1);
    send_byte(1'b0, 8'hA4, 2);
    check("latency", 32'(lat), 32'(SYNC + 3));
    check("head_a4", 32'({out_dc, out_data}), 32'h0A4);
    cs_high();
    check("fs_once", 32'(fs_cnt), 32'd1);
    check("fa_none", 32'(fa_cnt), 32'd0);
    out_ready = 1'b1;
    tick(2);
    check("t1_n", 32'(got_q.size()), 32'd1);
    expect_entry("t1_e0", 9'h0A4);
    check("t1_empty", 32'(out_valid), 32'h0);

    // Three data bytes in one frame, consumer always ready
    cs_low();
    send_byte(1'b1, 8'h12, 0);
    send_byte(1'b1, 8'h34, 0);
    send_byte(1'b1, 8'h56, 0);
    cs_high();
    check("t2_n", 32'(got_q.size()), 32'd3);
    expect_entry("t2_e0", 9'h112);
    expect_entry("t2_e1", 9'h134);
    expect_entry("t2_e2", 9'h156);

    // Abort after 5 bits, then a clean frame
    fa0 = fa_cnt;
    cs_low();
    spi_dc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spi_do = 1'b1; tick(6); spi_sk = 1'b1; tick(6); spi_sk = 1'b0;
    end
    cs_high();
    check("t3_abort", 32'(fa_cnt - fa0), 32'd1);
    check("t3_nopush", 32'(got_q.size()), 32'd0);
    cs_low();
    send_byte(1'b0, 8'h81, 0);
    cs_high();
    check("t3_n", 32'(got_q.size()), 32'd1);
    expect_entry("t3_e0", 9'h081);
    check("t3_fa_clean", 32'(fa_cnt - fa0), 32'd1);

    // Overflow: 10 bytes into 8 slots
    out_ready = 1'b0;
    cs_low();
    for (int b = 0; b < 10; b++) send_byte(1'b1, 8'(b), 0);
    cs_high();
    check("t4_ovf", 32'(overflow), 32'h1);
    out_ready = 1'b1;
    tick(12);
    out_ready = 1'b0;
    check("t4_n", 32'(got_q.size()), 32'd8);
    for (int b = 0; b < 8; b++) expect_entry($sformatf("t4_e%0d", b), 9'h100 | 9'(b));
    check("t4_ovf_hold", 32'(overflow), 32'h1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'h0);

    // Full FIFO: push coincides with a pop
    cs_low();
    for (int b = 0; b < 8; b++) send_byte(1'b0, 8'h20 + 8'(b), 0);
    check("t5_full_ovf", 32'(overflow), 32'h0);
    send_byte(1'b0, 8'h28, 1);
    cs_high();
    check("t5_ovf", 32'(overflow), 32'h0);
    check("t5_one_pop", 32'(got_q.size()), 32'd1);
    out_ready = 1'b1;
    tick(12);
    out_ready = 1'b0;
    check("t5_n", 32'(got_q.size()), 32'd9);
    for (int b = 0; b < 9; b++) expect_entry($sformatf("t5_e%0d", b), 9'h020 + 9'(b));

    // Reset mid-byte with CS held low
    cs_low();
    send_byte(1'b1, 8'h5A, 0);
    for (int i = 0; i < 4; i++) begin
      spi_do = 1'b1; tick(6); spi_sk = 1'b1; tick(6); spi_sk = 1'b0;
    end
    check("t6_pre_valid", 32'(out_valid), 32'h1);
    resetn = 1'b0;
    #2;
    check("t6_rst_outs", 32'({out_valid, out_data, out_dc, frame_active, frame_start,
                              frame_abort, overflow}), 32'h0);
    tick(3);
    resetn = 1'b1;
    fs0 = fs_cnt;
    fa0 = fa_cnt;
    tick(4);
    send_byte(1'b1, 8'h77, 0);
    send_byte(1'b1, 8'h66, 0);
    tick(6);
    check("t6_ignored", 32'(out_valid), 32'h0);
    check("t6_no_fs", 32'(fs_cnt - fs0), 32'd0);
    cs_high();
    cs_low();
    send_byte(1'b0, 8'h3C, 0);
    cs_high();
    check("t6_fs", 32'(fs_cnt - fs0), 32'd1);
    check("t6_fa", 32'(fa_cnt - fa0), 32'd0);
`ifdef SPI_RX_STATS_EN
    check("t6_byte_cnt", 32'(byte_count), 32'd1);
    check("t6_frame_cnt", 32'(frame_count), 32'd1);
`endif
    out_ready = 1'b1;
    tick(2);
    check("t6_n", 32'(got_q.size()), 32'd1);
    expect_entry("t6_e0", 9'h03C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
